// File: rtl/tile_sprite_mapper_pkg.sv
// Shared types and helpers for the tile/sprite colour mapper.
package tile_mapper_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [23:0] TRANSPARENT_DEF = 24'hFF00FF;

  // Address width needed to index n entries (at least one bit).
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/tile_sprite_mapper_if.sv
// Memory-side bus: map RAM, tile ROM and sprite ROM address/data pairs.
interface tile_sprite_mapper_if
  import tile_mapper_pkg::*;
#(
  parameter int unsigned TILE_W      = 16,
  parameter int unsigned MAP_COLS    = 20,
  parameter int unsigned MAP_ROWS    = 20,
  parameter int unsigned TILE_ID_W   = 5,
  parameter int unsigned ANIM_FRAMES = 4
);
  localparam int unsigned TW_LOG2 = addr_w(TILE_W);
  localparam int unsigned MAP_AW  = addr_w(MAP_COLS * MAP_ROWS);
  localparam int unsigned FRAME_W = addr_w(ANIM_FRAMES);
  localparam int unsigned TILE_AW = TILE_ID_W + 2 * TW_LOG2;
  localparam int unsigned SPR_AW  = 1 + FRAME_W + 2 * TW_LOG2;

  logic [MAP_AW-1:0]    map_addr;
  logic [TILE_ID_W-1:0] map_tile;
  logic [TILE_AW-1:0]   tile_rom_addr;
  rgb_t                 tile_rgb;
  logic [SPR_AW-1:0]    spr_rom_addr;
  rgb_t                 spr_rgb;

  modport master (
    output map_addr, tile_rom_addr, spr_rom_addr,
    input  map_tile, tile_rgb, spr_rgb
  );

  modport slave (
    input  map_addr, tile_rom_addr, spr_rom_addr,
    output map_tile, tile_rgb, spr_rgb
  );

endinterface

// File: rtl/tile_sprite_mapper_anim_timer.sv
// Sprite animation frame counter (stepped by frame pulses) and facing flag.
module anim_timer
  import tile_mapper_pkg::*;
#(
  parameter int unsigned ANIM_FRAMES = 4,
  parameter int unsigned FRAME_DIV   = 15,
  localparam int unsigned FRAME_W    = addr_w(ANIM_FRAMES)
)(
  input  logic               Clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               dir_left,
  input  logic               dir_right,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               facing_left
);

  localparam int unsigned DIV_W = addr_w(FRAME_DIV);

  logic [DIV_W-1:0] div_cnt;

  // Divide frame pulses down to animation steps; frame wraps naturally (power of two).
  always_ff @(posedge Clk) begin
    if (reset) begin
      div_cnt    <= '0;
      anim_frame <= '0;
    end else if (frame_start) begin
      if (32'(div_cnt) == FRAME_DIV - 1) begin
        div_cnt    <= '0;
        anim_frame <= anim_frame + FRAME_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Facing: a single-sided request changes it, conflicting or absent requests hold.
  always_ff @(posedge Clk) begin
    if (reset) begin
      facing_left <= 1'b0;
    end else if (dir_left && !dir_right) begin
      facing_left <= 1'b1;
    end else if (dir_right && !dir_left) begin
      facing_left <= 1'b0;
    end
  end

endmodule

// File: rtl/tile_sprite_mapper.sv
// Three-stage pixel pipeline: map lookup, texel fetch, colour-key composite.
module tile_sprite_mapper
  import tile_mapper_pkg::*;
#(
  parameter int unsigned TILE_W      = 16,
  parameter int unsigned MAP_COLS    = 20,
  parameter int unsigned MAP_ROWS    = 20,
  parameter int unsigned TILE_ID_W   = 5,
  parameter int unsigned ANIM_FRAMES = 4,
  parameter int unsigned FRAME_DIV   = 15,
  parameter logic [23:0] TRANSPARENT = TRANSPARENT_DEF,
  localparam int unsigned TW_LOG2    = addr_w(TILE_W)
)(
  input  logic               Clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               frame_start,
  tile_sprite_mapper_if.master mem,
  input  logic [9:0]         spr_x,
  input  logic [9:0]         spr_y,
  input  logic [TW_LOG2:0]   spr_w,
  input  logic [TW_LOG2:0]   spr_h,
  input  logic               spr_moving,
  input  logic               dir_left,
  input  logic               dir_right,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue
);

  localparam int unsigned MAP_AW  = addr_w(MAP_COLS * MAP_ROWS);
  localparam int unsigned FRAME_W = addr_w(ANIM_FRAMES);

  logic [FRAME_W-1:0] anim_frame;
  logic               facing_left;

  anim_timer #(
    .ANIM_FRAMES (ANIM_FRAMES),
    .FRAME_DIV   (FRAME_DIV)
  ) u_anim (
    .Clk         (Clk),
    .reset       (reset),
    .frame_start (frame_start),
    .dir_left    (dir_left),
    .dir_right   (dir_right),
    .anim_frame  (anim_frame),
    .facing_left (facing_left)
  );

  // Stage 1 state: pixel plus the sprite state it was sampled with.
  logic [9:0]       x1, y1, sx1, sy1;
  logic [TW_LOG2:0] sw1, sh1;
  logic             mv1, in_map1;

  // Stage 2 state.
  logic             in_map2, hit2;

  logic [9:0]         col_c, row_c;
  logic               in_map_c;
  logic               hit_c;
  logic [TW_LOG2-1:0] lcol_c, lcol_sel_c, lrow_c;
  rgb_t               pix_c;

  // Tile coordinates of the incoming pixel and map bounds test.
  always_comb begin
    col_c    = DrawX >> TW_LOG2;
    row_c    = DrawY >> TW_LOG2;
    in_map_c = (32'(col_c) < MAP_COLS) && (32'(row_c) < MAP_ROWS);
  end

  // Stage 1: register pixel/sprite state and issue the map RAM read.
  always_ff @(posedge Clk) begin
    if (reset) begin
      x1           <= '0;
      y1           <= '0;
      sx1          <= '0;
      sy1          <= '0;
      sw1          <= '0;
      sh1          <= '0;
      mv1          <= 1'b0;
      in_map1      <= 1'b0;
      mem.map_addr <= '0;
    end else begin
      x1           <= DrawX;
      y1           <= DrawY;
      sx1          <= spr_x;
      sy1          <= spr_y;
      sw1          <= spr_w;
      sh1          <= spr_h;
      mv1          <= spr_moving;
      in_map1      <= in_map_c;
      mem.map_addr <= in_map_c ? MAP_AW'(32'(row_c) * MAP_COLS + 32'(col_c)) : '0;
    end
  end

  // Sprite hit test in 11 bits so spr_x+spr_w cannot wrap; local texel coordinates.
  always_comb begin
    hit_c = (11'(x1) >= 11'(sx1)) && (11'(x1) < 11'(sx1) + 11'(sw1)) &&
            (11'(y1) >= 11'(sy1)) && (11'(y1) < 11'(sy1) + 11'(sh1));
    lcol_c     = TW_LOG2'(x1 - sx1);
    lrow_c     = TW_LOG2'(y1 - sy1);
    lcol_sel_c = facing_left ? TW_LOG2'(sw1 - (TW_LOG2 + 1)'(1) - (TW_LOG2 + 1)'(lcol_c))
                             : lcol_c;
  end

  // Stage 2: issue tile and sprite ROM reads.
  always_ff @(posedge Clk) begin
    if (reset) begin
      mem.tile_rom_addr <= '0;
      mem.spr_rom_addr  <= '0;
      in_map2           <= 1'b0;
      hit2              <= 1'b0;
    end else begin
      mem.tile_rom_addr <= {mem.map_tile, y1[TW_LOG2-1:0], x1[TW_LOG2-1:0]};
      mem.spr_rom_addr  <= hit_c ? {mv1, anim_frame, lrow_c, lcol_sel_c} : '0;
      in_map2           <= in_map1;
      hit2              <= hit_c;
    end
  end

  // Composite: an opaque sprite texel wins, even over the black border outside the map.
  always_comb begin
    pix_c = '0;
    if (hit2 && (mem.spr_rgb != TRANSPARENT)) begin
      pix_c = mem.spr_rgb;
    end else if (in_map2) begin
      pix_c = mem.tile_rgb;
    end
  end

  // Stage 3: output colour register.
  always_ff @(posedge Clk) begin
    if (reset) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else begin
      Red   <= pix_c.r;
      Green <= pix_c.g;
      Blue  <= pix_c.b;
    end
  end

endmodule
